// File: rtl/ysyx_22051013_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Define YSYX_22051013_MDU_EARLY_EN to let divide-by-zero, signed overflow and zero-operand multiplies skip the iteration.
module ysyx_22051013_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mdu_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_res,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        cnt_reg;
    logic [3:0]        op_reg;
    logic              w_reg, mul_reg, neg_q_reg, neg_r_reg;
    logic              div_zero_reg, ovf_reg, mul_zero_reg;
    logic [XLEN-1:0]   a_reg, b_reg, hi_reg, lo_reg;

    // Request decode, evaluated on the raw inputs in the accept cycle
    logic              dec_w, dec_mul, dec_div, dec_illegal;
    logic              sign1_en, sign2_en, dec_s1, dec_s2;
    logic [31:0]       op1_w, op2_w, op1_w_mag, op2_w_mag;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              dec_div_zero, dec_ovf, dec_mul_zero, dec_early;
    logic              accept;

    always_comb begin
        dec_illegal = (mdu_op >= 4'd13);
        dec_mul     = (mdu_op <= 4'd4);
        dec_div     = !dec_mul && !dec_illegal;
        dec_w       = (mdu_op == 4'd4) || ((mdu_op >= 4'd9) && (mdu_op <= 4'd12));
        sign1_en    = (mdu_op == 4'd1) || (mdu_op == 4'd2) || (mdu_op == 4'd5) ||
                      (mdu_op == 4'd7) || (mdu_op == 4'd9) || (mdu_op == 4'd11);
        sign2_en    = (mdu_op == 4'd1) || (mdu_op == 4'd5) || (mdu_op == 4'd7) ||
                      (mdu_op == 4'd9) || (mdu_op == 4'd11);
        op1_w       = op1[31:0];
        op2_w       = op2[31:0];
        dec_s1      = sign1_en && (dec_w ? op1[31] : op1[63]);
        dec_s2      = sign2_en && (dec_w ? op2[31] : op2[63]);
        op1_w_mag   = dec_s1 ? (~op1_w + 32'd1) : op1_w;
        op2_w_mag   = dec_s2 ? (~op2_w + 32'd1) : op2_w;
        a_mag       = dec_w ? {32'b0, op1_w_mag} : (dec_s1 ? (~op1 + 64'd1) : op1);
        b_mag       = dec_w ? {32'b0, op2_w_mag} : (dec_s2 ? (~op2 + 64'd1) : op2);
        dec_div_zero = dec_div && (b_mag == '0);
        dec_ovf      = dec_div && sign1_en &&
                       (dec_w ? ((op1_w == 32'h8000_0000) && (op2_w == 32'hFFFF_FFFF))
                              : ((op1 == 64'h8000_0000_0000_0000) && (op2 == '1)));
        dec_mul_zero = dec_mul && ((a_mag == '0) || (b_mag == '0));
`ifdef YSYX_22051013_MDU_EARLY_EN
        dec_early    = dec_div_zero || dec_ovf || dec_mul_zero;
`else
        dec_early    = 1'b0;
`endif
    end

    assign accept = (state_reg == IDLE) && in_valid && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = (dec_illegal || dec_early) ? DONE : CALC;
            CALC: if (cnt_reg == 7'd1) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Outputs are forced low while rst is high
    logic [XLEN-1:0] res_final;
    always_comb begin
        in_ready  = (state_reg == IDLE) && !rst;
        busy      = (state_reg != IDLE) && !rst;
        out_valid = (state_reg == DONE) && !rst;
        mdu_res   = out_valid ? res_final : '0;
    end

    // One iteration: multiply shifts {hi,lo} right, divide shifts left
    logic [XLEN:0]   mul_sum, div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_sub, hi_step, lo_step;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
        div_shift = {hi_reg, lo_reg[63]};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_sub   = div_shift[63:0] - b_reg;
        if (mul_reg) begin
            hi_step = mul_sum[64:1];
            lo_step = {mul_sum[0], lo_reg[63:1]};
        end else if (div_ge) begin
            hi_step = div_sub;
            lo_step = {lo_reg[62:0], 1'b1};
        end else begin
            hi_step = div_shift[63:0];
            lo_step = {lo_reg[62:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            op_reg       <= '0;
            w_reg        <= 1'b0;
            mul_reg      <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            mul_zero_reg <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else if (accept) begin
            cnt_reg      <= dec_w ? 7'd32 : 7'd64;
            op_reg       <= mdu_op;
            w_reg        <= dec_w;
            mul_reg      <= dec_mul;
            neg_q_reg    <= dec_s1 ^ dec_s2;
            neg_r_reg    <= dec_s1;
            div_zero_reg <= dec_div_zero;
            ovf_reg      <= dec_ovf;
            mul_zero_reg <= dec_mul_zero;
            a_reg        <= a_mag;
            b_reg        <= b_mag;
            hi_reg       <= '0;
            // W divides start with the 32-bit dividend in the top half so 32 shifts consume it
            lo_reg       <= dec_mul ? b_mag : (dec_w ? {a_mag[31:0], 32'b0} : a_mag);
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg - 7'd1;
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
        end
    end

    // Sign fix-up and result selection on the held registers
    logic [XLEN-1:0] mulh_hi, quot_mag, quot, rem, dividend, res_raw;

    always_comb begin
        // High half of the negated 128-bit product: carry into it only when the low half is zero
        mulh_hi  = neg_q_reg ? (~hi_reg + {63'b0, (lo_reg == '0)}) : hi_reg;
        quot_mag = w_reg ? {32'b0, lo_reg[31:0]} : lo_reg;
        quot     = neg_q_reg ? (~quot_mag + 64'd1) : quot_mag;
        rem      = neg_r_reg ? (~hi_reg + 64'd1) : hi_reg;
        dividend = neg_r_reg ? (~a_reg + 64'd1) : a_reg;
        case (op_reg)
            4'd0:                     res_raw = lo_reg;
            4'd1, 4'd2, 4'd3:         res_raw = mulh_hi;
            4'd4:                     res_raw = {32'b0, lo_reg[63:32]};
            4'd5, 4'd6, 4'd9, 4'd10:  res_raw = div_zero_reg ? '1 : (ovf_reg ? dividend : quot);
            4'd7, 4'd8, 4'd11, 4'd12: res_raw = div_zero_reg ? dividend : (ovf_reg ? '0 : rem);
            default:                  res_raw = '0;
        endcase
        if (mul_zero_reg) res_raw = '0;
        res_final = w_reg ? {{32{res_raw[31]}}, res_raw[31:0]} : res_raw;
    end

endmodule

// File: tb/tb_ysyx_22051013_mdu.sv
// Directed vector bench for ysyx_22051013_mdu: result, latency and handshake checks plus flush/stall/reset sequences.
module tb_ysyx_22051013_mdu;

`ifdef YSYX_22051013_MDU_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  mdu_op = '0;
    logic [63:0] op1 = '0;
    logic [63:0] op2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] mdu_res;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22051013_mdu #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mdu_op(mdu_op), .op1(op1), .op2(op2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .mdu_res(mdu_res), .busy(busy)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Edges after the accept edge until out_valid is seen (cycle number minus one)
    function automatic int explat(bit w, bit sp, bit ill);
        if (ill) return 0;
        if (EARLY && sp) return 0;
        return w ? 32 : 64;
    endfunction

    task automatic add(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input int lat, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        chk("in_ready before issue", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b1; mdu_op = op; op1 = a; op2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input vec_t v);
        int lat;
        start(v.op, v.a, v.b);
        wait_valid(lat);
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " result"}, mdu_res, v.res);
        $display("vec %-24s op=%0d a=%h b=%h res=%h out_valid_cycle=%0d", v.name, v.op, v.a, v.b, mdu_res, lat + 1);
        @(posedge clk); #1;
        chk({v.name, " in_ready after"}, {63'b0, in_ready}, 64'd1);
        chk({v.name, " out_valid after"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        vec_t v;

        add(4'd0,  64'h3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, explat(0,0,0), "MUL 3*-5");
        add(4'd3,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, explat(0,0,0), "MULHU max*max");
        add(4'd5,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, explat(0,0,0), "DIV -7/2");
        add(4'd7,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, explat(0,0,0), "REM -7/2");
        add(4'd6,  64'd5, 64'd0, '1, explat(0,1,0), "DIVU 5/0");
        add(4'd8,  64'd5, 64'd0, 64'd5, explat(0,1,0), "REMU 5/0");
        add(4'd5,  64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, explat(0,1,0), "DIV ovf");
        add(4'd7,  64'h8000_0000_0000_0000, '1, 64'd0, explat(0,1,0), "REM ovf");
        add(4'd9,  64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, explat(1,1,0), "DIVW ovf");
        add(4'd11, 64'h8000_0000, '1, 64'd0, explat(1,1,0), "REMW ovf");
        add(4'd1,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, '1, explat(0,0,0), "MULH -2*3");
        add(4'd1,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, explat(0,0,0), "MULH min*min");
        add(4'd2,  '1, 64'd2, '1, explat(0,0,0), "MULHSU -1*2");
        add(4'd2,  64'd2, 64'h8000_0000_0000_0000, 64'd1, explat(0,0,0), "MULHSU 2*2^63");
        add(4'd4,  64'hDEAD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, explat(1,0,0), "MULW");
        add(4'd9,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, explat(1,0,0), "DIVW -7/2");
        add(4'd11, 64'hFFFF_FFF9, 64'd2, '1, explat(1,0,0), "REMW -7/2");
        add(4'd12, 64'hFFFF_FFFF, 64'd10, 64'd5, explat(1,0,0), "REMUW max/10");
        add(4'd5,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, '1, explat(0,1,0), "DIV -7/0");
        add(4'd7,  64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, explat(0,1,0), "REM -7/0");
        add(4'd0,  64'd0, 64'd5, 64'd0, explat(0,1,0), "MUL 0*5");
        add(4'd13, 64'd9, 64'd9, 64'd0, explat(0,0,1), "illegal op 13");

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {63'b0, in_ready}, 64'd0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset mdu_res", mdu_res, 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", {63'b0, in_ready}, 64'd1);

        foreach (vecs[i]) begin
            v = vecs[i];
            run(v);
        end

        // Flush in cycle 10 of a MUL, then a fresh DIVU accepted in cycle 11
        start(4'd0, 64'd123, 64'd456);
        repeat (9) @(posedge clk);
        #1;
        chk("busy during MUL", {63'b0, busy}, 64'd1);
        chk("mdu_res zero in CALC", mdu_res, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush busy", {63'b0, busy}, 64'd0);
        chk("flush in_ready", {63'b0, in_ready}, 64'd1);
        $display("seq flush of MUL in cycle 10");
        v.op = 4'd6; v.a = 64'd100; v.b = 64'd7; v.res = 64'd14; v.lat = explat(0,0,0); v.name = "DIVU 100/7 after flush";
        run(v);

        // Result held while the consumer stalls
        out_ready = 1'b0;
        start(4'd10, 64'd100, 64'd7);
        wait_valid(lat);
        chk("DIVUW stall latency", 64'(lat), 64'd32);
        for (int k = 0; k < 5; k++) begin
            chk("DIVUW stall result", mdu_res, 64'd14);
            chk("DIVUW stall out_valid", {63'b0, out_valid}, 64'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk("DIVUW release result", mdu_res, 64'd14);
        @(posedge clk); #1;
        chk("DIVUW consumed", {63'b0, out_valid}, 64'd0);
        $display("seq DIVUW 100/7 with 5-cycle stall res=14");

        // Reset in cycle 3 of a 64-bit divide
        start(4'd6, 64'd1000, 64'd3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midop rst out_valid", {63'b0, out_valid}, 64'd0);
        chk("midop rst busy", {63'b0, busy}, 64'd0);
        chk("midop rst in_ready", {63'b0, in_ready}, 64'd0);
        chk("midop rst mdu_res", mdu_res, 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after midop rst", {63'b0, in_ready}, 64'd1);
        chk("busy after midop rst", {63'b0, busy}, 64'd0);
        $display("seq reset in cycle 3 of DIVU");
        v.op = 4'd6; v.a = 64'd1000; v.b = 64'd3; v.res = 64'd333; v.lat = explat(0,0,0); v.name = "DIVU 1000/3 after rst";
        run(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
